// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug transmit path: arbiter state encoding,
// requester IDs, the default lock-timeout limit and the tie-break helper.
package uart_dbg_pkg;

    // State encoding doubles as the one-hot grant vector {OWN1, OWN0}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic REQ_DUMP = 1'b0;
    localparam logic REQ_ECHO = 1'b1;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1023;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_winner(
        input logic r0,
        input logic r1,
        input logic last_served
    );
        logic win;
        if (r0 && r1) begin
            win = ~last_served;
        end else if (r1) begin
            win = REQ_ECHO;
        end else begin
            win = REQ_DUMP;
        end
        return win;
    endfunction

    function automatic logic [1:0] grant_of(input arb_state_e st);
        return {(st == ST_OWN1), (st == ST_OWN0)};
    endfunction

endpackage

// File: rtl/arb_stall_timer.sv
// Stall counter for a locked owner that has stopped offering bytes; expired
// rises when the count reaches TIMEOUT_CYCLES-1. Used under UART_TX_ARB_TIMEOUT_EN.
module arb_stall_timer
    import uart_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(32'd1);

    logic [CNT_W-1:0] count_r;

    assign expired = (count_r == TC_VAL);

    // Stall count: cleared by the arbiter, saturates at the terminal count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (advance && !expired) begin
            count_r <= count_r + ONE_VAL;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet-locking arbiter in front of the UART TX FIFO.
// Optional owner-stall timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_dbg_pkg::*;
#(
    parameter int unsigned DATA_W         = 32'd8,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              last0,
    input  logic              last1,
    output logic              ack0,
    output logic              ack1,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_flag
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              last_served_r;
    logic              last_nxt_s;
    logic              wr_s;
    logic [DATA_W-1:0] data_s;
    logic              ack0_s;
    logic              ack1_s;
    logic              stall_clr_s;
    logic              stall_adv_s;
    logic              stall_expired_s;
    logic              to_set_s;

    // Next-state, FIFO write path and stall-timer control.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_served_r;
        wr_s        = 1'b0;
        data_s      = {DATA_W{1'b0}};
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        stall_clr_s = 1'b0;
        stall_adv_s = 1'b0;
        to_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Grant takes effect next cycle; nothing is written while idle.
                if (req0 || req1) begin
                    stall_clr_s = 1'b1;
                    if (pick_winner(req0, req1, last_served_r) == REQ_ECHO) begin
                        state_nxt_s = ST_OWN1;
                    end else begin
                        state_nxt_s = ST_OWN0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                data_s = data0;
                wr_s   = req0 & ~fifo_full;
                ack0_s = wr_s;
                if (wr_s) begin
                    stall_clr_s = 1'b1;
                    if (last0) begin
                        state_nxt_s = ST_IDLE;
                        last_nxt_s  = REQ_DUMP;
                    end else begin
                        state_nxt_s = ST_OWN0;
                    end
                end else if (!req0 && !fifo_full) begin
                    stall_adv_s = 1'b1;
                    if (stall_expired_s) begin
                        state_nxt_s = ST_IDLE;
                        last_nxt_s  = REQ_DUMP;
                        to_set_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_OWN0;
                    end
                end else begin
                    state_nxt_s = ST_OWN0;
                end
            end
            ST_OWN1: begin
                data_s = data1;
                wr_s   = req1 & ~fifo_full;
                ack1_s = wr_s;
                if (wr_s) begin
                    stall_clr_s = 1'b1;
                    if (last1) begin
                        state_nxt_s = ST_IDLE;
                        last_nxt_s  = REQ_ECHO;
                    end else begin
                        state_nxt_s = ST_OWN1;
                    end
                end else if (!req1 && !fifo_full) begin
                    stall_adv_s = 1'b1;
                    if (stall_expired_s) begin
                        state_nxt_s = ST_IDLE;
                        last_nxt_s  = REQ_ECHO;
                        to_set_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_OWN1;
                    end
                end else begin
                    state_nxt_s = ST_OWN1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state and round-robin history; requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            last_served_r <= REQ_ECHO;
        end else begin
            state_r       <= state_nxt_s;
            last_served_r <= last_nxt_s;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic timeout_flag_r;

    arb_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (stall_clr_s),
        .advance (stall_adv_s),
        .expired (stall_expired_s)
    );

    // Sticky timeout indicator, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_flag_r <= 1'b0;
        end else begin
            timeout_flag_r <= timeout_flag_r | to_set_s;
        end
    end

    assign timeout_flag = timeout_flag_r;
`else
    logic unused_timeout_s;

    assign stall_expired_s  = 1'b0;
    assign unused_timeout_s = ^{stall_clr_s, stall_adv_s, to_set_s, (TIMEOUT_CYCLES != 32'd0)};
    assign timeout_flag     = 1'b0;
`endif

    assign fifo_wr   = wr_s;
    assign fifo_data = data_s;
    assign ack0      = ack0_s;
    assign ack1      = ack1_s;
    assign grant     = grant_of(state_r);
    assign busy      = (state_r != ST_IDLE);

endmodule
